iterative_alu: RTL
==================

ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values even, 8 to 64.
REQ-002 SHALL have derived parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port Clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InValid  input  1  operation request valid.
REQ-006 SHALL have port InReady  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B.
REQ-009 SHALL have port FunSel  input  5  bit 4 width select (1 full WIDTH, 0 low half); bits 3:0 opcode.
REQ-010 SHALL have port ShAmt  input  SHW  shift count for shift opcodes.
REQ-011 SHALL have port WF  input  1  write-flags enable for this operation.
REQ-012 SHALL have port OutValid  output  1  ALUOut holds a completed result.
REQ-013 SHALL have port OutReady  input  1  consumer accepts the result.
REQ-014 SHALL have port ALUOut  output  WIDTH  registered result.
REQ-015 SHALL have port FlagsOut  output  4  registered flags {Z,C,N,O}, bit 3 = Z.

Function
REQ-016 SHALL capture A, B, FunSel, ShAmt, WF and current C flag when InValid && InReady (accept).
REQ-017 SHALL implement states IDLE, SHIFT, DONE; InReady = (IDLE) || (DONE && OutReady).
REQ-018 Opcodes 0000-1010 SHALL be A, B, ~A, ~B, A+B, A+B+C, A-B, A&B, A|B, A^B, ~(A&B); accepted in cycle k -> DONE, OutValid=1 in k+1.
REQ-019 Opcodes 1011 LSL, 1100 LSR, 1101 ASR, 1110 CSL (rotate left through C), 1111 CSR (rotate right through C) SHALL shift one bit per cycle in SHIFT; OutValid in k+1+ShAmt.
REQ-020 Shift with ShAmt=0 SHALL go directly to DONE in k+1 with ALUOut=A and C unchanged.
REQ-021 Each shift step: LSL/CSL C<=msb out; LSR/ASR/CSR C<=lsb out; fill: LSL/LSR 0, ASR msb, CSL/CSR old C; internal running C used, not FlagsOut, until DONE.
REQ-022 Half mode (FunSel[4]=0) SHALL operate on bits WIDTH/2-1:0 only; ALUOut sign-extended from bit WIDTH/2-1; flags taken at half width.
REQ-023 Z SHALL be 1 iff the (full or half) result is zero; N SHALL be result msb.
REQ-024 C for add SHALL be carry out of msb; for A-B SHALL be 1 iff A<B unsigned (borrow).
REQ-025 O SHALL be signed overflow for add (same operand signs, result sign differs) and sub (operand signs differ, result sign equals B sign).
REQ-026 Flag update SHALL occur on DONE entry only if latched WF=1: Z,N all opcodes; C arithmetic and shift opcodes; O arithmetic opcodes only; other flags hold.
REQ-027 In DONE, ALUOut and OutValid SHALL hold stable until OutReady=1; then DONE->IDLE, or DONE->next op if accept occurs same cycle.
REQ-028 Inputs other than at accept SHALL be ignored; InValid while InReady=0 SHALL not change state.
REQ-029 ShAmt >= half width in half mode SHALL still iterate ShAmt steps within the half.

Reset
REQ-030 Reset low SHALL immediately force state IDLE, OutValid=0, ALUOut=0, FlagsOut=0000, internal counters 0, regardless of operation in progress.
REQ-031 After Reset rises, InReady SHALL be 1 on the first rising edge.

Verification (WIDTH=32)
REQ-032 A=FFFFFFFF, B=00000001, FunSel=10100, WF=1 -> next cycle OutValid=1, ALUOut=00000000, FlagsOut=1100.
REQ-033 A=00000005, B=00000007, FunSel=00110, WF=1 -> ALUOut=FFFFFFFE, Z=0, C=1, N=1, O=0.
REQ-034 A=F0000001, FunSel=11011, ShAmt=4, WF=1 -> OutValid exactly 5 cycles after accept, ALUOut=00000010, C=1, N=0.
REQ-035 Result held with OutReady=0 for 3 cycles -> ALUOut, OutValid stable, InReady=0; OutReady=1 with InValid=1 -> new op accepted that cycle, OutValid remains 1 next cycle with new result.
REQ-036 Reset low at step 5 of ShAmt=20 shift -> OutValid=0, ALUOut=0, FlagsOut=0000 without waiting for Clock; InReady=1 after release.
REQ-037 Prior C=1, A=1, B=1, FunSel=10101, WF=0 -> ALUOut=00000003, FlagsOut unchanged.

Source files
------------

// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops plus one-bit-per-cycle shifts and rotates.
// Full or half-width operation; {Z,C,N,O} flags committed when the result is presented.
module iterative_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic [SHW-1:0]   ShAmt,
    input  logic             WF,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);

    localparam int unsigned HW = WIDTH / 2;

    localparam logic [3:0] OP_A    = 4'd0;
    localparam logic [3:0] OP_B    = 4'd1;
    localparam logic [3:0] OP_NA   = 4'd2;
    localparam logic [3:0] OP_NB   = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_ADC  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NAND = 4'd10;
    localparam logic [3:0] OP_LSL  = 4'd11;
    localparam logic [3:0] OP_LSR  = 4'd12;
    localparam logic [3:0] OP_ASR  = 4'd13;
    localparam logic [3:0] OP_CSL  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic             r_full;
    logic             r_wf;
    logic             r_c;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_alu;
    logic [3:0]       r_flags;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_to_shift;
    logic             w_cin;
    logic [WIDTH:0]   w_sum_f;
    logic [WIDTH:0]   w_dif_f;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_acc_raw;
    logic             w_acc_c;
    logic             w_acc_o;
    logic             w_acc_rs;
    logic [WIDTH-1:0] w_step;
    logic             w_step_c;
    logic             w_msb_out;
    logic             w_fill;
    logic             w_left;
    logic             w_src_shift;
    logic [WIDTH-1:0] w_cm_raw;
    logic             w_cm_c;
    logic             w_cm_o;
    logic [3:0]       w_cm_op;
    logic             w_cm_full;
    logic             w_cm_wf;
    logic [WIDTH-1:0] w_cm_res;
    logic             w_cm_z;
    logic             w_cm_arith;
    logic             w_cm_shift;
    logic [3:0]       w_cm_flags;

    assign InReady    = (r_state == S_IDLE) || ((r_state == S_DONE) && OutReady);
    assign OutValid   = r_out_valid;
    assign ALUOut     = r_alu;
    assign FlagsOut   = r_flags;

    assign w_accept   = InValid && InReady;
    assign w_to_shift = (FunSel[3:0] >= OP_LSL) && (ShAmt != '0);

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (InValid) begin
                    w_next = w_to_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (OutReady) begin
                    if (InValid) begin
                        w_next = w_to_shift ? S_SHIFT : S_DONE;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Single-cycle result; half-width carry/borrow is recovered from the bit just above the half
    assign w_cin   = (FunSel[3:0] == OP_ADC) ? r_flags[2] : 1'b0;
    assign w_sum_f = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(w_cin);
    assign w_dif_f = {1'b0, A} - {1'b0, B};
    assign w_sa    = FunSel[4] ? A[WIDTH-1] : A[HW-1];
    assign w_sb    = FunSel[4] ? B[WIDTH-1] : B[HW-1];

    always_comb begin
        w_acc_raw = A;
        w_acc_c   = r_flags[2];
        w_acc_o   = 1'b0;
        case (FunSel[3:0])
            OP_A:    w_acc_raw = A;
            OP_B:    w_acc_raw = B;
            OP_NA:   w_acc_raw = ~A;
            OP_NB:   w_acc_raw = ~B;
            OP_ADD, OP_ADC: begin
                w_acc_raw = w_sum_f[WIDTH-1:0];
                w_acc_c   = FunSel[4] ? w_sum_f[WIDTH] : (w_sum_f[HW] ^ A[HW] ^ B[HW]);
            end
            OP_SUB: begin
                w_acc_raw = w_dif_f[WIDTH-1:0];
                w_acc_c   = FunSel[4] ? w_dif_f[WIDTH] : (w_dif_f[HW] ^ A[HW] ^ B[HW]);
            end
            OP_AND:  w_acc_raw = A & B;
            OP_OR:   w_acc_raw = A | B;
            OP_XOR:  w_acc_raw = A ^ B;
            OP_NAND: w_acc_raw = ~(A & B);
            default: w_acc_raw = A;
        endcase
        w_acc_rs = FunSel[4] ? w_acc_raw[WIDTH-1] : w_acc_raw[HW-1];
        if ((FunSel[3:0] == OP_ADD) || (FunSel[3:0] == OP_ADC)) begin
            w_acc_o = (w_sa == w_sb) && (w_acc_rs != w_sa);
        end else if (FunSel[3:0] == OP_SUB) begin
            w_acc_o = (w_sa != w_sb) && (w_acc_rs == w_sb);
        end
    end

    // One shift/rotate step on the working register; half mode keeps the upper half zero
    always_comb begin
        w_msb_out = r_full ? r_work[WIDTH-1] : r_work[HW-1];
        w_fill    = r_c;
        w_left    = 1'b0;
        case (r_op)
            OP_LSL: begin w_fill = 1'b0;      w_left = 1'b1; end
            OP_LSR: begin w_fill = 1'b0;      w_left = 1'b0; end
            OP_ASR: begin w_fill = w_msb_out; w_left = 1'b0; end
            OP_CSL: begin w_fill = r_c;       w_left = 1'b1; end
            default: begin w_fill = r_c;      w_left = 1'b0; end
        endcase
        if (w_left) begin
            w_step   = {r_work[WIDTH-2:0], w_fill};
            w_step_c = w_msb_out;
            if (!r_full) begin
                w_step[WIDTH-1:HW] = '0;
            end
        end else begin
            w_step   = {1'b0, r_work[WIDTH-1:1]};
            w_step_c = r_work[0];
            if (r_full) begin
                w_step[WIDTH-1] = w_fill;
            end else begin
                w_step[HW-1] = w_fill;
            end
        end
    end

    // Result/flag commit, sourced from the accept path or the final shift step
    always_comb begin
        w_src_shift = (r_state == S_SHIFT);
        w_cm_raw    = w_src_shift ? w_step   : w_acc_raw;
        w_cm_c      = w_src_shift ? w_step_c : w_acc_c;
        w_cm_o      = w_src_shift ? 1'b0     : w_acc_o;
        w_cm_op     = w_src_shift ? r_op     : FunSel[3:0];
        w_cm_full   = w_src_shift ? r_full   : FunSel[4];
        w_cm_wf     = w_src_shift ? r_wf     : WF;
        w_cm_res    = w_cm_full ? w_cm_raw : {{HW{w_cm_raw[HW-1]}}, w_cm_raw[HW-1:0]};
        w_cm_z      = w_cm_full ? (w_cm_raw == '0) : (w_cm_raw[HW-1:0] == '0);
        w_cm_arith  = (w_cm_op >= OP_ADD) && (w_cm_op <= OP_SUB);
        w_cm_shift  = (w_cm_op >= OP_LSL);
        w_cm_flags  = r_flags;
        if (w_cm_wf) begin
            w_cm_flags[3] = w_cm_z;
            w_cm_flags[1] = w_cm_res[WIDTH-1];
            if (w_cm_arith || w_cm_shift) begin
                w_cm_flags[2] = w_cm_c;
            end
            if (w_cm_arith) begin
                w_cm_flags[0] = w_cm_o;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_op        <= '0;
            r_full      <= 1'b0;
            r_wf        <= 1'b0;
            r_c         <= 1'b0;
            r_work      <= '0;
            r_cnt       <= '0;
            r_alu       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_next == S_DONE);
            if (w_accept) begin
                r_op   <= FunSel[3:0];
                r_full <= FunSel[4];
                r_wf   <= WF;
                r_c    <= r_flags[2];
                r_cnt  <= ShAmt;
                r_work <= FunSel[4] ? A : {{HW{1'b0}}, A[HW-1:0]};
                if (!w_to_shift) begin
                    r_alu   <= w_cm_res;
                    r_flags <= w_cm_flags;
                end
            end else if (r_state == S_SHIFT) begin
                r_work <= w_step;
                r_c    <= w_step_c;
                r_cnt  <= r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    r_alu   <= w_cm_res;
                    r_flags <= w_cm_flags;
                end
            end
        end
    end

endmodule
